// File: rtl/data_ram_pipe_pkg.sv
// Shared encodings for the byte-lane data RAM with a one-entry store buffer.
package data_ram_pipe_pkg;

    localparam logic CE_ON     = 1'b1;
    localparam logic CE_OFF    = 1'b0;
    localparam logic WE_WRITE  = 1'b1;
    localparam logic WE_READ   = 1'b0;

    // One lane of the zero word used by the clear sweep.
    localparam logic [7:0] ZERO_BYTE = 8'h00;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

endpackage

// File: rtl/data_ram_pipe_if.sv
// Request/response bundle between a requester and data_ram_pipe.
interface data_ram_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    localparam int LANES = DATA_W / 8;

    logic              ce;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  sel;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              rvalid_o;
    logic              ready_o;
    logic              err_o;

    modport master (
        output ce, we, addr, sel, data_i,
        input  data_o, rvalid_o, ready_o, err_o
    );

    modport slave (
        input  ce, we, addr, sel, data_i,
        output data_o, rvalid_o, ready_o, err_o
    );
endinterface

// File: rtl/data_ram_lane.sv
// One byte-wide DEPTH-entry array: synchronous write, asynchronous read.
module data_ram_lane #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [7:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [7:0]               rdata
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/data_ram_pipe.sv
// Byte-lane data RAM with a zero-fill sweep, a single-entry store buffer
// and one-cycle registered reads that forward from the pending write.
module data_ram_pipe
    import data_ram_pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst,
    data_ram_pipe_if.slave  bus
);
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam state_e RST_STATE =
        (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
    localparam logic RST_READY = (CLEAR_ON_RESET == 0);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;
    logic              ready_q, ready_d;
    logic              buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]  buf_idx_q, buf_idx_d;
    logic [LANES-1:0]  buf_sel_q, buf_sel_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    logic              accept;
    logic              misalign;
    logic              buf_hit;
    logic [IDX_W-1:0]  req_idx;
    logic [LANES-1:0]  lane_we;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] arr_word;

    assign req_idx  = bus.addr[LANE_W+IDX_W-1:LANE_W];
    assign misalign = (bus.addr[LANE_W-1:0] != '0);
    assign accept   = (bus.ce == CE_ON) && ready_q;
    assign buf_hit  = buf_valid_q && (buf_idx_q == req_idx);

    if (ADDR_W > LANE_W + IDX_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.addr[ADDR_W-1:LANE_W+IDX_W];
    end

    // The sweep owns the write port in INIT; otherwise the buffer commits.
    always_comb begin
        lane_we = '0;
        wr_idx  = buf_idx_q;
        wr_data = buf_data_q;
        if (state_q == ST_INIT) begin
            lane_we = '1;
            wr_idx  = sweep_q;
            wr_data = {LANES{ZERO_BYTE}};
        end else if (buf_valid_q) begin
            lane_we = buf_sel_q;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        data_ram_lane #(
            .DEPTH (DEPTH)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[i]),
            .waddr (wr_idx),
            .wdata (wr_data[8*i +: 8]),
            .raddr (req_idx),
            .rdata (arr_word[8*i +: 8])
        );
    end

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        ready_d     = ready_q;
        buf_valid_d = 1'b0;
        buf_idx_d   = buf_idx_q;
        buf_sel_d   = buf_sel_q;
        buf_data_d  = buf_data_q;
        data_d      = '0;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    sweep_d = '0;
                end
            end
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = RST_STATE;
                ready_d = RST_READY;
            end
        endcase

        if (accept) begin
            err_d = (bus.sel == '0) || ((&bus.sel) && misalign);
            if (bus.we == WE_WRITE) begin
                buf_valid_d = 1'b1;
                buf_idx_d   = req_idx;
                buf_sel_d   = bus.sel;
                buf_data_d  = bus.data_i;
            end else begin
                rvalid_d = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    if (bus.sel[i]) begin
                        data_d[8*i +: 8] = (buf_hit && buf_sel_q[i])
                            ? buf_data_q[8*i +: 8]
                            : arr_word[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            sweep_q     <= '0;
            ready_q     <= RST_READY;
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_sel_q   <= '0;
            buf_data_q  <= '0;
            data_q      <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            ready_q     <= ready_d;
            buf_valid_q <= buf_valid_d;
            buf_idx_q   <= buf_idx_d;
            buf_sel_q   <= buf_sel_d;
            buf_data_q  <= buf_data_d;
            data_q      <= data_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
        end
    end

    assign bus.data_o   = data_q;
    assign bus.rvalid_o = rvalid_q;
    assign bus.ready_o  = ready_q;
    assign bus.err_o    = err_q;
endmodule

// File: doc/data_ram_pipe.md
DATA_RAM_PIPE -- requirements
Module: data_ram_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; a multiple of 8; LANES = DATA_W/8.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words; a power of 2.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, enabling the zero-fill sweep after reset.
REQ-005 SHALL have one clock and an asynchronous active-high reset, with ports clk and rst as named below.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 ce  input  1  access request, qualified by ready_o.
REQ-009 we  input  1  1 = write, 0 = read.
REQ-010 addr  input  ADDR_W  byte address; word index = addr[log2(LANES)+log2(DEPTH)-1 : log2(LANES)]; upper bits ignored.
REQ-011 sel  input  LANES  byte-lane enables; sel[i] selects data bits [8i+7:8i].
REQ-012 data_i  input  DATA_W  write data.
REQ-013 data_o  output  DATA_W  registered read data.
REQ-014 rvalid_o  output  1  data_o valid this cycle.
REQ-015 ready_o  output  1  block accepts requests.
REQ-016 err_o  output  1  one-cycle pulse for a malformed access.

Function
REQ-017 An access SHALL be accepted on a rising edge only when ce=1 and ready_o=1; all other requests SHALL be ignored with no side effects.
REQ-018 FSM SHALL have the states INIT and IDLE; ready_o=1 only in IDLE.
REQ-019 With CLEAR_ON_RESET=1, the FSM SHALL leave reset in INIT and write zero to all lanes of index 0..DEPTH-1, one index per cycle, then enter IDLE; the sweep SHALL last exactly DEPTH cycles.
REQ-020 With CLEAR_ON_RESET=0, the FSM SHALL leave reset in IDLE, and array contents SHALL be undefined.
REQ-021 An accepted write SHALL load the single-entry store buffer {valid, index, sel, data} on that edge, and commit it to the array, on selected lanes only, on the next edge.
REQ-022 A write accepted on the commit edge SHALL commit the old entry and load the new entry on the same edge, with no stall; back-to-back writes to the same index SHALL resolve oldest-first.
REQ-023 A read accepted at edge t SHALL drive data_o and rvalid_o=1 during cycle t+1; latency SHALL be 1 cycle.
REQ-024 Read data SHALL be the array word, with each lane taken from the store buffer where the buffer is valid, its index matches and buffer sel[i]=1.
REQ-025 Lanes with sel[i]=0 on a read SHALL return 0; sel=all-ones SHALL return the full word.
REQ-026 In any cycle not following an accepted read, data_o SHALL be 0 and rvalid_o SHALL be 0.
REQ-027 err_o SHALL pulse during cycle t+1 for an access accepted at t with sel=0, or with sel=all-ones and addr[log2(LANES)-1:0]!=0.
REQ-028 An erroneous access SHALL still execute with its given sel (sel=0 has no effect on memory).

Reset
REQ-029 When rst=1, the block SHALL enter INIT (or IDLE if CLEAR_ON_RESET=0), clear the sweep counter and store buffer valid, and set data_o=0, rvalid_o=0, err_o=0, and ready_o=0 (CLEAR_ON_RESET=1) or ready_o=1 (CLEAR_ON_RESET=0).
REQ-030 A reset during INIT SHALL restart the sweep at index 0.
REQ-031 A reset while the buffer is valid SHALL discard the pending write.

Structure
REQ-032 ChipEnable/WriteEnable encodings, ZeroWord and FSM state encodings SHALL live in the shared defines file.
REQ-033 A sub-module data_ram_lane SHALL implement one byte-wide DEPTH-entry array with write enable; it SHALL be instantiated LANES times.

Verification
(Each line: DATA_W=32, DEPTH=16, CLEAR_ON_RESET=1 unless stated.)
REQ-034 Release reset -> ready_o=0 for 16 cycles then 1; a read of addr 0x3C with sel=F -> data_o=0x00000000, rvalid_o=1 one cycle later.
REQ-035 Write 0x11223344 to 0x08 with sel=F, then on the next cycle read 0x08 with sel=F -> data_o=0x11223344 (forwarded).
REQ-036 Write 0xAABBCCDD to 0x04 with sel=F, then write 0x000000EE to 0x04 with sel=1, then read 0x04 with sel=F -> 0xAABBCCEE.
REQ-037 Read 0x06 with sel=F -> err_o=1 for one cycle; read 0x04 with sel=0 -> err_o=1 and data_o=0.
REQ-038 Assert rst at sweep index 7 -> after release, ready_o stays 0 for 16 full cycles; a write followed by reset before commit -> a later read returns 0.
REQ-039 With ce=1 during INIT -> no write lands and rvalid_o stays 0; with ADDR index 17 -> the access aliases to index 1.
